aes_in_packer: RTL and testbench

- Upstream feeder for the AES encryption top.
- Accepts a 32-bit plaintext word stream (valid/ready) and assembles 128-bit blocks into a small block FIFO.
- Holds a shadow and an active 256-bit key with its mode, and issues one block at a time to the core using the core's data/key/mode inputs and ready output.
- Between issues it drives mode NOOP so the core holds its state.

---
 rtl/aes_in_packer.sv | 200 ++++++++++++++++++++
 tb/tb_aes_in_packer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_in_packer.sv
// Packs a 32-bit plaintext word stream into 128-bit blocks for the AES core.
// Each block is issued with a single-cycle mode pulse using the active key.
module aes_in_packer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid_i,
  input  logic [31:0]      s_data_i,
  output logic             s_ready_o,
  input  logic             key_wr_i,
  input  logic [2:0]       key_idx_i,
  input  logic [31:0]      key_word_i,
  input  logic [1:0]       key_mode_i,
  input  logic             key_commit_i,
  input  logic             core_ready_i,
  output logic [127:0]     core_data_o,
  output logic [255:0]     core_key_o,
  output logic [1:0]       core_mode_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] blk_cnt_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT_LO = 2'd2;
  localparam logic [1:0] ST_WAIT_HI = 2'd3;

  localparam logic [1:0] MODE_NOOP = 2'd0;

  logic [1:0]       word_cnt_q, word_cnt_d;
  logic [95:0]      asm_q, asm_d;
  logic [127:0]     mem_q [DEPTH];
  logic [127:0]     mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fifo_cnt_q, fifo_cnt_d;
  logic [255:0]     shadow_q, shadow_d;
  logic [255:0]     active_key_q, active_key_d;
  logic [1:0]       active_mode_q, active_mode_d;
  logic             key_valid_q, key_valid_d;
  logic             pend_q, pend_d;
  logic [1:0]       pend_mode_q, pend_mode_d;
  logic [1:0]       state_q, state_d;
  logic [127:0]     data_q, data_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [1:0]       lo_cnt_q, lo_cnt_d;

  logic fifo_full, fifo_empty, accept, push, pop, commit_go, issue_go;

  assign fifo_full  = (fifo_cnt_q == (AW+1)'(DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);
  assign s_ready_o  = !rst && !(word_cnt_q == 2'd3 && fifo_full);
  assign accept     = s_valid_i && s_ready_o;
  assign push       = accept && (word_cnt_q == 2'd3);
  // A pending commit steals the IDLE cycle so the block goes out with the new key.
  assign commit_go  = pend_q && (state_q == ST_IDLE);
  assign issue_go   = (state_q == ST_IDLE) && !pend_q && key_valid_q && !fifo_empty && core_ready_i;
  assign pop        = issue_go;

  assign core_data_o = data_q;
  assign core_key_o  = active_key_q;
  assign core_mode_o = mode_q;
  assign blk_cnt_o   = blk_cnt_q;
  assign busy_o      = (state_q != ST_IDLE) || !fifo_empty || (word_cnt_q != 2'd0);

  always_comb begin
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (accept) begin
      word_cnt_d = word_cnt_q + 2'd1;
      asm_d      = {asm_q[63:0], s_data_i};
    end
    if (push) begin
      mem_d[wr_ptr_q] = {asm_q, s_data_i};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + (AW+1)'(1);
    end else if (pop && !push) begin
      fifo_cnt_d = fifo_cnt_q - (AW+1)'(1);
    end
  end

  always_comb begin
    shadow_d      = shadow_q;
    active_key_d  = active_key_q;
    active_mode_d = active_mode_q;
    key_valid_d   = key_valid_q;
    pend_d        = pend_q;
    pend_mode_d   = pend_mode_q;
    if (key_wr_i) begin
      for (int i = 0; i < 8; i++) begin
        if (key_idx_i == 3'(i)) begin
          shadow_d[255-32*i -: 32] = key_word_i;
        end
      end
    end
    if (commit_go) begin
      active_key_d  = shadow_d;
      active_mode_d = pend_mode_q;
      key_valid_d   = (pend_mode_q != MODE_NOOP);
      pend_d        = 1'b0;
    end
    if (key_commit_i) begin
      pend_d      = 1'b1;
      pend_mode_d = key_mode_i;
    end
  end

  // WAIT_LO gives up after four ready-high cycles in case the core never drops ready.
  always_comb begin
    state_d   = state_q;
    mode_d    = MODE_NOOP;
    data_d    = data_q;
    blk_cnt_d = blk_cnt_q;
    lo_cnt_d  = lo_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_go) begin
          data_d    = mem_q[rd_ptr_q];
          mode_d    = active_mode_q;
          blk_cnt_d = blk_cnt_q + CNT_W'(1);
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lo_cnt_d = 2'd0;
        state_d  = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!core_ready_i) begin
          state_d = ST_WAIT_HI;
        end else if (lo_cnt_q == 2'd3) begin
          state_d = ST_IDLE;
        end else begin
          lo_cnt_d = lo_cnt_q + 2'd1;
        end
      end
      ST_WAIT_HI: begin
        if (core_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q    <= '0;
      asm_q         <= '0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      shadow_q      <= '0;
      active_key_q  <= '0;
      active_mode_q <= MODE_NOOP;
      key_valid_q   <= 1'b0;
      pend_q        <= 1'b0;
      pend_mode_q   <= MODE_NOOP;
      state_q       <= ST_IDLE;
      data_q        <= '0;
      mode_q        <= MODE_NOOP;
      blk_cnt_q     <= '0;
      lo_cnt_q      <= '0;
    end else begin
      word_cnt_q    <= word_cnt_d;
      asm_q         <= asm_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      shadow_q      <= shadow_d;
      active_key_q  <= active_key_d;
      active_mode_q <= active_mode_d;
      key_valid_q   <= key_valid_d;
      pend_q        <= pend_d;
      pend_mode_q   <= pend_mode_d;
      state_q       <= state_d;
      data_q        <= data_d;
      mode_q        <= mode_d;
      blk_cnt_q     <= blk_cnt_d;
      lo_cnt_q      <= lo_cnt_d;
    end
  end

endmodule

// File: tb/tb_aes_in_packer.sv
// Scoreboard bench for aes_in_packer: stimulus pushes expected issues, a monitor
// pops them on every core mode pulse; a small core model drops ready after each issue.
module tb_aes_in_packer;

  localparam int DEPTH = 2;
  // Narrow counter so the wrap-around is reachable in a short run.
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid_i = 1'b0;
  logic [31:0]      s_data_i = '0;
  logic             s_ready_o;
  logic             key_wr_i = 1'b0;
  logic [2:0]       key_idx_i = '0;
  logic [31:0]      key_word_i = '0;
  logic [1:0]       key_mode_i = '0;
  logic             key_commit_i = 1'b0;
  logic             core_ready_i;
  logic [127:0]     core_data_o;
  logic [255:0]     core_key_o;
  logic [1:0]       core_mode_o;
  logic             busy_o;
  logic [CNT_W-1:0] blk_cnt_o;

  logic holdReady = 1'b0;
  logic emuBusy   = 1'b0;
  logic monOn     = 1'b0;
  logic pulseSeen = 1'b0;

  assign core_ready_i = !holdReady && !emuBusy;

  aes_in_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .key_wr_i(key_wr_i), .key_idx_i(key_idx_i), .key_word_i(key_word_i),
    .key_mode_i(key_mode_i), .key_commit_i(key_commit_i),
    .core_ready_i(core_ready_i), .core_data_o(core_data_o), .core_key_o(core_key_o),
    .core_mode_o(core_mode_o), .busy_o(busy_o), .blk_cnt_o(blk_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       mode;
    logic [127:0]     data;
    logic [255:0]     key;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  logic [CNT_W-1:0] expCnt = '0;
  int checks = 0;
  int passes = 0;

  localparam logic [255:0] K1 = 256'h2b7e151628aed2a6abf7158809cf4f3c_00000000000000000000000000000000;
  localparam logic [255:0] K2 = 256'h000102030405060708090a0b0c0d0e0f_101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K3 = 256'h603deb1015ca71be2b73aef0857d7781_1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] PT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BB = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] BC = 128'hdeadbeefcafebabe0badf00dfeedface;
  localparam logic [127:0] BD = 128'h11111111222222223333333344444444;
  localparam logic [127:0] BE = 128'h55555555666666667777777788888888;
  localparam logic [127:0] BF = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] BG = 128'hf0e0d0c0b0a090807060504030201000;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic pushExp(input logic [127:0] blk, input logic [1:0] mode, input logic [255:0] key);
    exp_t e;
    expCnt = expCnt + CNT_W'(1);
    e.mode = mode;
    e.data = blk;
    e.key  = key;
    e.cnt  = expCnt;
    expQ.push_back(e);
  endtask

  task automatic waitAccept(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_ready_o) begin
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
        return;
      end
    end
    checks++;
    $display("[TB] FAIL %s: s_ready_o stayed 0 for 40 cycles, expected acceptance", name);
    s_valid_i = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    s_valid_i = 1'b1;
    s_data_i  = w;
    waitAccept("word_accept");
  endtask

  // Sends one block as four words, first word from the top bits, and optionally
  // records the issue it should produce.
  task automatic applyStimulus(input logic [127:0] blk, input logic [1:0] mode,
                               input logic [255:0] key, input logic doPush);
    for (int i = 0; i < 4; i++) sendWord(blk[127-32*i -: 32]);
    if (doPush) pushExp(blk, mode, key);
  endtask

  task automatic writeKey(input logic [255:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      key_wr_i   = 1'b1;
      key_idx_i  = 3'(i);
      key_word_i = k[255-32*i -: 32];
      @(posedge clk);
      #1;
    end
    key_wr_i = 1'b0;
  endtask

  task automatic commitKey(input logic [1:0] m);
    key_mode_i   = m;
    key_commit_i = 1'b1;
    @(posedge clk);
    #1;
    key_commit_i = 1'b0;
  endtask

  task automatic waitPulse(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (core_mode_o != 2'd0) return;
    end
    checks++;
    $display("[TB] FAIL %s: no core_mode_o pulse within 60 cycles, expected one", name);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every non-NOOP mode must match the head of the queue and last one cycle.
  always @(negedge clk) begin
    if (monOn) begin
      if (pulseSeen) checkOutput("pulse_width", 256'(core_mode_o), 256'(0));
      pulseSeen = (core_mode_o != 2'd0);
      if (core_mode_o != 2'd0) begin
        if (expQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_issue: got mode %0d data %h, expected no issue", core_mode_o, core_data_o);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("issue_mode", 256'(core_mode_o), 256'(monExp.mode));
          checkOutput("issue_data", 256'(core_data_o), 256'(monExp.data));
          checkOutput("issue_key", core_key_o, monExp.key);
          checkOutput("issue_cnt", 256'(blk_cnt_o), 256'(monExp.cnt));
        end
      end
    end
  end

  // Core model: after accepting a block, ready drops for two cycles.
  initial begin
    wait (monOn);
    forever begin
      @(negedge clk);
      if (core_mode_o != 2'd0) begin
        @(posedge clk);
        #1 emuBusy = 1'b1;
        repeat (2) @(posedge clk);
        #1 emuBusy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset with a word offered: nothing may be accepted or issued.
    rst = 1'b1;
    s_valid_i = 1'b1;
    s_data_i = 32'hcafef00d;
    @(posedge clk);
    monOn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_ready", 256'(s_ready_o), 256'(0));
      checkOutput("rst_mode", 256'(core_mode_o), 256'(0));
      checkOutput("rst_cnt", 256'(blk_cnt_o), 256'(0));
      checkOutput("rst_busy", 256'(busy_o), 256'(0));
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    s_valid_i = 1'b0;
    checkOutput("rst_key", core_key_o, 256'(0));

    // FIPS-197 style block with a 128-bit key committed as AES128.
    $display("[TB] basic issue");
    writeKey(K1, 4);
    commitKey(2'd1);
    applyStimulus(PT, 2'd1, K1, 1'b1);
    @(negedge clk);
    checkOutput("lat_early", 256'(core_mode_o), 256'(0));
    @(negedge clk);
    checkOutput("lat_issue", 256'(core_mode_o), 256'(1));
    idle(12);
    checkOutput("t2_cnt", 256'(blk_cnt_o), 256'(1));
    checkOutput("t2_busy", 256'(busy_o), 256'(0));

    // Backpressure: two full blocks plus three words fill everything.
    $display("[TB] backpressure");
    holdReady = 1'b1;
    applyStimulus(BA, 2'd1, K1, 1'b1);
    applyStimulus(BB, 2'd1, K1, 1'b1);
    for (int i = 0; i < 3; i++) sendWord(BC[127-32*i -: 32]);
    s_valid_i = 1'b1;
    s_data_i  = BC[31:0];
    @(negedge clk);
    checkOutput("bp_ready", 256'(s_ready_o), 256'(0));
    checkOutput("bp_busy", 256'(busy_o), 256'(1));
    holdReady = 1'b0;
    waitAccept("bp_word12");
    pushExp(BC, 2'd1, K1);
    idle(40);
    checkOutput("t3_drained", 256'(expQ.size()), 256'(0));

    // Commit while the FSM waits on the core: takes effect only back in IDLE.
    $display("[TB] commit during wait");
    writeKey(K2, 8);
    applyStimulus(BD, 2'd1, K1, 1'b1);
    waitPulse("t4_issue");
    @(posedge clk);
    @(posedge clk);
    #1;
    key_mode_i   = 2'd3;
    key_commit_i = 1'b1;
    @(posedge clk);
    #1;
    key_commit_i = 1'b0;
    @(negedge clk);
    checkOutput("key_hold_a", core_key_o, K1);
    @(negedge clk);
    checkOutput("key_hold_b", core_key_o, K1);
    @(negedge clk);
    checkOutput("key_new", core_key_o, K2);
    @(posedge clk);
    #1;
    applyStimulus(BE, 2'd3, K2, 1'b1);
    idle(15);
    checkOutput("t4_cnt", 256'(blk_cnt_o), 256'(6));

    // Fresh reset, no commit: blocks accumulate but are never issued.
    $display("[TB] no key");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expCnt = '0;
    checkOutput("t5_rst_key", core_key_o, 256'(0));
    writeKey(K3, 8);
    applyStimulus(BF, 2'd2, K3, 1'b0);
    applyStimulus(BG, 2'd2, K3, 1'b0);
    idle(10);
    checkOutput("t5_no_issue", 256'(blk_cnt_o), 256'(0));
    checkOutput("t5_busy", 256'(busy_o), 256'(1));
    pushExp(BF, 2'd2, K3);
    pushExp(BG, 2'd2, K3);
    commitKey(2'd2);
    idle(30);
    checkOutput("t5_drained", 256'(expQ.size()), 256'(0));
    checkOutput("t5_cnt", 256'(blk_cnt_o), 256'(2));

    // Run the counter through its all-ones value.
    $display("[TB] counter wrap");
    for (int i = 0; i < 14; i++) begin
      applyStimulus({32'ha5a50000 | 32'(i), 32'h5a5a0000 | 32'(i), 32'h3c3c0000 | 32'(i), 32'hc3c30000 | 32'(i)},
                    2'd2, K3, 1'b1);
    end
    idle(30);
    checkOutput("cnt_wrap", 256'(blk_cnt_o), 256'(0));
    checkOutput("wrap_drained", 256'(expQ.size()), 256'(0));

    // Reset during ISSUE with a second block still queued.
    $display("[TB] reset mid-issue");
    holdReady = 1'b1;
    applyStimulus(BA, 2'd2, K3, 1'b1);
    applyStimulus(BB, 2'd2, K3, 1'b0);
    holdReady = 1'b0;
    waitPulse("rst_issue");
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_mode", 256'(core_mode_o), 256'(0));
    checkOutput("rst_mid_busy", 256'(busy_o), 256'(0));
    checkOutput("rst_mid_ready", 256'(s_ready_o), 256'(0));
    checkOutput("rst_mid_cnt", 256'(blk_cnt_o), 256'(0));
    checkOutput("rst_mid_data", 256'(core_data_o), 256'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);
    checkOutput("post_rst_busy", 256'(busy_o), 256'(0));
    checkOutput("post_rst_cnt", 256'(blk_cnt_o), 256'(0));
    checkOutput("queue_empty", 256'(expQ.size()), 256'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
